// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: default sizing shared by the register file, its interface and scoreboard
package regfile_sb_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NB_REGS = 32;
  localparam int RF_ADR_W = $clog2(RF_NB_REGS);
  localparam int RF_NB_RD = 2;
  localparam int RF_NB_WR = 1;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the register file
// master drives reads, writes, issue and flush; slave returns read data, ready and pending bits
interface regfile_sb_if import regfile_sb_pkg::*; #(
  parameter int XLEN = RF_XLEN,
  parameter int NB_REGS = RF_NB_REGS,
  parameter int NB_RD = RF_NB_RD,
  parameter int NB_WR = RF_NB_WR,
  localparam int ADR_W = $clog2(NB_REGS)
);
  logic [NB_RD-1:0] rd_v_i;
  logic [NB_RD*ADR_W-1:0] rd_adr_i;
  logic [NB_RD*XLEN-1:0] rd_data_o;
  logic [NB_RD-1:0] rd_ready_o;
  logic [NB_WR-1:0] wr_v_i;
  logic [NB_WR*ADR_W-1:0] wr_adr_i;
  logic [NB_WR*XLEN-1:0] wr_data_i;
  logic iss_v_i;
  logic [ADR_W-1:0] iss_adr_i;
  logic flush_i;
  logic [NB_REGS-1:0] pending_o;
  modport master (
    output rd_v_i, rd_adr_i, wr_v_i, wr_adr_i, wr_data_i, iss_v_i, iss_adr_i, flush_i,
    input rd_data_o, rd_ready_o, pending_o
  );
  modport slave (
    input rd_v_i, rd_adr_i, wr_v_i, wr_adr_i, wr_data_i, iss_v_i, iss_adr_i, flush_i,
    output rd_data_o, rd_ready_o, pending_o
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register pending bits set on issue, cleared on writeback or flush
// ports: clk, reset, i_iss_v/i_iss_adr (issue), i_wr_v/i_wr_adr (writeback), i_flush, o_pending
module regfile_scoreboard import regfile_sb_pkg::*; #(
  parameter int NB_REGS = RF_NB_REGS,
  parameter int NB_WR = RF_NB_WR,
  localparam int ADR_W = $clog2(NB_REGS)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_iss_v,
  input  logic [ADR_W-1:0] i_iss_adr,
  input  logic [NB_WR-1:0] i_wr_v,
  input  logic [NB_WR*ADR_W-1:0] i_wr_adr,
  input  logic i_flush,
  output logic [NB_REGS-1:0] o_pending
);
  logic [NB_REGS-1:0] r_pending;
  logic [NB_REGS-1:0] w_set;
  logic [NB_REGS-1:0] w_clr;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_v) w_set[i_iss_adr] = 1'b1;
    for (int j = 0; j < NB_WR; j++)
      if (i_wr_v[j]) w_clr[i_wr_adr[j*ADR_W +: ADR_W]] = 1'b1;
  end
  // set is applied after clear so a new producer beats a same-cycle writeback; bit 0 is masked off
  always_ff @(posedge clk)
    if (reset || i_flush) r_pending <= '0;
    else r_pending <= ((r_pending & ~w_clr) | w_set) & ~NB_REGS'(1);
  assign o_pending = r_pending;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with x0 = 0, write bypass and pending scoreboard
// ports: clk, reset (sync, active-high), bus (regfile_sb_if.slave: reads, writes, issue, flush, pending)
module regfile_sb import regfile_sb_pkg::*; #(
  parameter int XLEN = RF_XLEN,
  parameter int NB_REGS = RF_NB_REGS,
  parameter int NB_RD = RF_NB_RD,
  parameter int NB_WR = RF_NB_WR,
  parameter bit BYPASS = 1'b1,
  localparam int ADR_W = $clog2(NB_REGS)
) (
  input logic clk,
  input logic reset,
  regfile_sb_if.slave bus
);
  logic [XLEN-1:0] r_regs [NB_REGS];
  logic [NB_REGS-1:0] w_pending;
  logic [NB_RD*XLEN-1:0] w_rd_data;
  logic [NB_RD-1:0] w_rd_ready;
  logic [ADR_W-1:0] w_radr;
  logic [XLEN-1:0] w_val;
  logic w_hit;
  regfile_scoreboard #(.NB_REGS(NB_REGS), .NB_WR(NB_WR)) u_sb (
    .clk(clk),
    .reset(reset),
    .i_iss_v(bus.iss_v_i),
    .i_iss_adr(bus.iss_adr_i),
    .i_wr_v(bus.wr_v_i),
    .i_wr_adr(bus.wr_adr_i),
    .i_flush(bus.flush_i),
    .o_pending(w_pending)
  );
  // later write ports are assigned last, so the highest hitting port wins
  always_ff @(posedge clk)
    if (reset) r_regs <= '{default: '0};
    else
      for (int j = 0; j < NB_WR; j++)
        if (bus.wr_v_i[j] && bus.wr_adr_i[j*ADR_W +: ADR_W] != '0)
          r_regs[bus.wr_adr_i[j*ADR_W +: ADR_W]] <= bus.wr_data_i[j*XLEN +: XLEN];
  always_comb begin
    w_rd_data = '0;
    w_rd_ready = '0;
    w_radr = '0;
    w_val = '0;
    w_hit = 1'b0;
    for (int k = 0; k < NB_RD; k++) begin
      w_radr = bus.rd_adr_i[k*ADR_W +: ADR_W];
      w_val = r_regs[w_radr];
      w_hit = 1'b0;
      for (int j = 0; j < NB_WR; j++)
        if (BYPASS && bus.wr_v_i[j] && bus.wr_adr_i[j*ADR_W +: ADR_W] == w_radr) begin
          w_hit = 1'b1;
          w_val = bus.wr_data_i[j*XLEN +: XLEN];
        end
      w_rd_data[k*XLEN +: XLEN] = (bus.rd_v_i[k] && w_radr != '0) ? w_val : '0;
      w_rd_ready[k] = bus.rd_v_i[k] && (w_radr == '0 || !w_pending[w_radr] || w_hit);
    end
  end
  assign bus.rd_data_o = w_rd_data;
  assign bus.rd_ready_o = w_rd_ready;
  assign bus.pending_o = w_pending;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb (2 read, 2 write ports, bypass on)
module tb_regfile_sb;
  typedef struct {
    string nm;
    int kind;
    logic [31:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  exp_t e;
  logic [31:0] got;
  int n_vec = 0;
  int n_err = 0;
  regfile_sb_if #(.XLEN(32), .NB_REGS(32), .NB_RD(2), .NB_WR(2)) bus ();
  regfile_sb #(.XLEN(32), .NB_REGS(32), .NB_RD(2), .NB_WR(2), .BYPASS(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // kind: 0 = port0 data, 1 = port1 data, 2 = ready vector, 3 = pending vector
  always @(negedge clk)
    while (q.size() > 0) begin
      e = q.pop_front();
      got = e.kind == 0 ? bus.rd_data_o[31:0] :
            e.kind == 1 ? bus.rd_data_o[63:32] :
            e.kind == 2 ? {30'b0, bus.rd_ready_o} : bus.pending_o;
      n_vec++;
      if (got !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.nm, got, e.val);
      end
    end
  task automatic clr();
    bus.rd_v_i = '0;
    bus.rd_adr_i = '0;
    bus.wr_v_i = '0;
    bus.wr_adr_i = '0;
    bus.wr_data_i = '0;
    bus.iss_v_i = 1'b0;
    bus.iss_adr_i = '0;
    bus.flush_i = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_v_i = 2'b11;
    bus.rd_adr_i = {a1, a0};
  endtask
  task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
    bus.wr_v_i[j] = 1'b1;
    bus.wr_adr_i[j*5 +: 5] = a;
    bus.wr_data_i[j*32 +: 32] = d;
  endtask
  task automatic iss(input logic [4:0] a);
    bus.iss_v_i = 1'b1;
    bus.iss_adr_i = a;
  endtask
  task automatic ex(input string nm, input int kind, input logic [31:0] v);
    exp_t t;
    t.nm = nm;
    t.kind = kind;
    t.val = v;
    q.push_back(t);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    clr();
    reset = 1'b1;
    wr(0, 5, 32'h1111_1111);
    wr(1, 6, 32'h2222_2222);
    iss(8);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    ex("rst_pending", 3, 32'h0);
    for (int a = 0; a < 32; a += 2) begin
      rd(5'(a), 5'(a + 1));
      ex($sformatf("rst_x%0d", a), 0, 32'h0);
      ex($sformatf("rst_x%0d", a + 1), 1, 32'h0);
      ex("rst_rdy", 2, 32'h3);
      tick();
    end
    wr(0, 5, 32'hDEAD_BEEF);
    tick();
    rd(5, 5);
    ex("x5_p0", 0, 32'hDEAD_BEEF);
    ex("x5_p1", 1, 32'hDEAD_BEEF);
    ex("x5_rdy", 2, 32'h3);
    tick();
    bus.rd_adr_i = {5'd5, 5'd5};
    ex("gate_d0", 0, 32'h0);
    ex("gate_rdy", 2, 32'h0);
    tick();
    wr(0, 0, 32'hFFFF_FFFF);
    rd(0, 0);
    ex("x0_byp_d0", 0, 32'h0);
    ex("x0_byp_d1", 1, 32'h0);
    ex("x0_byp_rdy", 2, 32'h3);
    tick();
    rd(0, 0);
    ex("x0_next", 0, 32'h0);
    tick();
    wr(0, 7, 32'h1);
    wr(1, 7, 32'h2);
    rd(7, 5);
    ex("dual_byp", 0, 32'h2);
    ex("dual_other", 1, 32'hDEAD_BEEF);
    tick();
    rd(7, 7);
    ex("dual_stored", 0, 32'h2);
    tick();
    iss(3);
    rd(3, 3);
    ex("iss_same_rdy", 2, 32'h3);
    ex("iss_same_pend", 3, 32'h0);
    tick();
    bus.rd_v_i = 2'b01;
    bus.rd_adr_i = {5'd0, 5'd3};
    ex("x3_busy_rdy", 2, 32'h0);
    ex("x3_pend", 3, 32'h8);
    tick();
    bus.rd_v_i = 2'b01;
    bus.rd_adr_i = {5'd0, 5'd3};
    wr(0, 3, 32'h55);
    ex("wb_rdy", 2, 32'h1);
    ex("wb_byp", 0, 32'h55);
    ex("wb_gate_d1", 1, 32'h0);
    tick();
    rd(3, 3);
    ex("wb_pend_clr", 3, 32'h0);
    ex("wb_stored", 1, 32'h55);
    ex("wb_rdy_after", 2, 32'h3);
    tick();
    iss(4);
    wr(0, 4, 32'h44);
    tick();
    rd(4, 0);
    ex("iss_wins", 3, 32'h10);
    ex("x4_rdy", 2, 32'h2);
    ex("x4_data", 0, 32'h44);
    tick();
    iss(9);
    tick();
    ex("two_pend", 3, 32'h210);
    bus.flush_i = 1'b1;
    iss(11);
    wr(0, 10, 32'hA);
    rd(9, 10);
    ex("flush_rdy", 2, 32'h2);
    ex("flush_byp", 1, 32'hA);
    tick();
    rd(10, 0);
    ex("flush_pend", 3, 32'h0);
    ex("flush_wr", 0, 32'hA);
    tick();
    iss(0);
    tick();
    ex("iss_x0", 3, 32'h0);
    tick();
    reset = 1'b1;
    wr(0, 12, 32'h77);
    iss(12);
    tick();
    reset = 1'b0;
    rd(12, 5);
    ex("rst_ovr_x12", 0, 32'h0);
    ex("rst_ovr_x5", 1, 32'h0);
    ex("rst_ovr_pend", 3, 32'h0);
    tick();
    tick();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
